// File: rtl/cpu_dbg_pkg.sv
// Shared types and default timing constants for the CPU step/run debug controller.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        STEP  = 2'd1,
        RUN   = 2'd2,
        BREAK = 2'd3
    } step_state_t;

    // 10 ms debounce and 10 Hz run rate at the 50 MHz board clock
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int RUN_DIV_DEF         = 5000000;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low board key; emits a 1-cycle pulse per accepted press.
module key_debounce
    import cpu_dbg_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic KeyRaw,
    output logic Level,
    output logic Press
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_prev_q;
    logic             press_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], KeyRaw};
            level_prev_q <= level_q;
            press_q      <= level_prev_q & ~level_q;
            // Any sample agreeing with the current level restarts the stability window
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign Level = level_q;
    assign Press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable sequencer: single step, divided free-run, and PC breakpoint halt.
module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int RUN_DIV         = RUN_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        KeyStep,
    input  logic        KeyRun,
    input  logic        BreakEnable,
    input  logic [31:0] BreakPC,
    input  logic [31:0] TapPC,
    output logic        CpuEn,
    output logic        Step,
    output logic        Running,
    output logic        AtBreak,
    output logic [15:0] StepCount
);

    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic step_level, step_press;
    logic run_level, run_press;
    logic unused_levels;

    step_state_t      state_q;
    logic [DIV_W-1:0] div_q;
    logic             skip_q;
    logic             cpu_en_q;
    logic             running_q;
    logic             at_break_q;
    logic [15:0]      step_count_q;
    logic [15:0]      step_count_d;
    logic             bp_hit;

    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .clk    (clk),
        .rst_n  (rst_n),
        .KeyRaw (KeyStep),
        .Level  (step_level),
        .Press  (step_press)
    );

    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run_key (
        .clk    (clk),
        .rst_n  (rst_n),
        .KeyRaw (KeyRun),
        .Level  (run_level),
        .Press  (run_press)
    );

    assign unused_levels = step_level ^ run_level;

    // TapPC is held between enables, so a direct compare is safe; skip lets the
    // breakpoint instruction itself execute once after a resume.
    assign bp_hit       = BreakEnable && (TapPC == BreakPC) && !skip_q;
    assign step_count_d = step_count_q + {15'd0, cpu_en_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HALT;
            div_q        <= '0;
            skip_q       <= 1'b0;
            cpu_en_q     <= 1'b0;
            running_q    <= 1'b0;
            at_break_q   <= 1'b0;
            step_count_q <= '0;
        end else begin
            cpu_en_q     <= 1'b0;
            step_count_q <= step_count_d;
            // Run press is checked first everywhere so it wins over a coincident step press
            case (state_q)
                HALT: begin
                    if (run_press) begin
                        state_q   <= RUN;
                        div_q     <= '0;
                        running_q <= 1'b1;
                    end else if (step_press) begin
                        state_q  <= STEP;
                        cpu_en_q <= 1'b1;
                    end
                end
                STEP: begin
                    state_q <= HALT;
                end
                RUN: begin
                    if (run_press) begin
                        state_q   <= HALT;
                        running_q <= 1'b0;
                    end else if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (bp_hit) begin
                            state_q    <= BREAK;
                            running_q  <= 1'b0;
                            at_break_q <= 1'b1;
                        end else begin
                            cpu_en_q <= 1'b1;
                            skip_q   <= 1'b0;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (run_press) begin
                        state_q    <= RUN;
                        div_q      <= '0;
                        skip_q     <= 1'b1;
                        running_q  <= 1'b1;
                        at_break_q <= 1'b0;
                    end else if (step_press) begin
                        state_q    <= STEP;
                        cpu_en_q   <= 1'b1;
                        at_break_q <= 1'b0;
                    end
                end
                default: state_q <= HALT;
            endcase
        end
    end

    assign CpuEn     = cpu_en_q;
    assign Step      = cpu_en_q;
    assign Running   = running_q;
    assign AtBreak   = at_break_q;
    assign StepCount = step_count_q;

endmodule
